// File: rtl/dzcpu_useq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dzcpu_useq_pkg
// Description : Shared types, field helpers and opcode constants for the
//               dzcpu microcode sequencer and its microcode ROM.
// Revision    : 1.0 - initial release
// ============================================================================
package dzcpu_useq_pkg;

  localparam int DZ_UPC_W  = 8;
  localparam int DZ_FLOW_W = 3;
  localparam int DZ_ACT_W  = 5;
  localparam int DZ_ARG_W  = 4;
  localparam int DZ_UOP_W  = DZ_FLOW_W + DZ_ACT_W + DZ_ARG_W;

  // Flow-control codes carried in the uop MSBs
  typedef enum logic [2:0] {
    FL_OP         = 3'd0,
    FL_INC        = 3'd1,
    FL_EOF        = 3'd2,
    FL_INC_EOF    = 3'd3,
    FL_INC_EOF_Z  = 3'd4,
    FL_INC_EOF_NZ = 3'd5,
    FL_JCB        = 3'd6,
    FL_JMP        = 3'd7
  } flow_e;

  typedef enum logic [0:0] {
    ST_DISPATCH = 1'b0,
    ST_EXEC     = 1'b1
  } state_e;

  // Datapath action codes (meaning is owned by the datapath)
  localparam logic [DZ_ACT_W-1:0] ACT_NOP     = 5'd0;
  localparam logic [DZ_ACT_W-1:0] ACT_FETCH   = 5'd1;
  localparam logic [DZ_ACT_W-1:0] ACT_LD_LO   = 5'd2;
  localparam logic [DZ_ACT_W-1:0] ACT_LD_HI   = 5'd3;
  localparam logic [DZ_ACT_W-1:0] ACT_WR_RR   = 5'd4;
  localparam logic [DZ_ACT_W-1:0] ACT_ADDR_HL = 5'd5;
  localparam logic [DZ_ACT_W-1:0] ACT_MEM_WR  = 5'd6;
  localparam logic [DZ_ACT_W-1:0] ACT_DEC_HL  = 5'd7;
  localparam logic [DZ_ACT_W-1:0] ACT_BIT     = 5'd8;
  localparam logic [DZ_ACT_W-1:0] ACT_SET_Z   = 5'd9;
  localparam logic [DZ_ACT_W-1:0] ACT_ADD_PC  = 5'd10;
  localparam logic [DZ_ACT_W-1:0] ACT_PUSH_PC = 5'd11;
  localparam logic [DZ_ACT_W-1:0] ACT_JP_VEC  = 5'd12;

  // Operand selectors
  localparam logic [DZ_ARG_W-1:0] ARG_NONE = 4'd0;
  localparam logic [DZ_ARG_W-1:0] ARG_HL   = 4'd2;
  localparam logic [DZ_ARG_W-1:0] ARG_SP   = 4'd3;
  localparam logic [DZ_ARG_W-1:0] ARG_A    = 4'd7;

  // Macro opcodes with microcode flows
  localparam logic [7:0] LDSPnn = 8'h31;
  localparam logic [7:0] LDHLnn = 8'h21;
  localparam logic [7:0] LDHLDA = 8'h32;
  localparam logic [7:0] MAPcb  = 8'hCB;
  localparam logic [7:0] JRNZn  = 8'h20;
  localparam logic [7:0] JRn    = 8'h18;
  localparam logic [7:0] TRAPop = 8'hD3;
  localparam logic [7:0] CB_BIT7H = 8'h7C;

  function automatic flow_e uop_flow(input logic [DZ_UOP_W-1:0] uop);
    return flow_e'(uop[DZ_UOP_W-1 -: DZ_FLOW_W]);
  endfunction

  function automatic logic [DZ_ACT_W-1:0] uop_act(input logic [DZ_UOP_W-1:0] uop);
    return uop[DZ_ARG_W +: DZ_ACT_W];
  endfunction

  function automatic logic [DZ_ARG_W-1:0] uop_arg(input logic [DZ_UOP_W-1:0] uop);
    return uop[DZ_ARG_W-1:0];
  endfunction

  function automatic logic [DZ_UOP_W-1:0] mk_uop(input flow_e f,
                                                 input logic [DZ_ACT_W-1:0] a,
                                                 input logic [DZ_ARG_W-1:0] g);
    return {f, a, g};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dzcpu_useq_rom.sv
`default_nettype none
// ============================================================================
// Module      : dzcpu_useq_rom
// Description : Combinational microcode store: primary opcode LUT, 0xCB
//               prefix LUT and the uop ROM. Holds no sequencing logic.
// Revision    : 1.0 - initial release
// ============================================================================
module dzcpu_useq_rom
  import dzcpu_useq_pkg::*;
(
  input  logic [DZ_UPC_W-1:0] upc_i,
  input  logic [7:0]          mop_i,
  output logic [DZ_UOP_W-1:0] uop_o,
  output logic [DZ_UPC_W-1:0] lut_upc_o,
  output logic [DZ_UPC_W-1:0] cblut_upc_o
);

  // Primary opcode to flow entry; unmapped opcodes land on the generic flow at 0
  always_comb begin
    lut_upc_o = '0;
    case (mop_i)
      LDSPnn:  lut_upc_o = 8'd1;
      LDHLnn:  lut_upc_o = 8'd5;
      LDHLDA:  lut_upc_o = 8'd9;
      MAPcb:   lut_upc_o = 8'd13;
      JRNZn:   lut_upc_o = 8'd17;
      JRn:     lut_upc_o = 8'd40;
      TRAPop:  lut_upc_o = 8'd250;
      default: lut_upc_o = '0;
    endcase
  end

  // CB second byte to flow entry; a miss falls back to the generic flow
  always_comb begin
    cblut_upc_o = '0;
    case (mop_i)
      CB_BIT7H: cblut_upc_o = 8'd14;
      default:  cblut_upc_o = '0;
    endcase
  end

  // Uop store; empty slots read as FL_OP/NOP so a flow missing its end runs away
  always_comb begin
    uop_o = '0;
    case (upc_i)
      // generic one-cycle flow: skip the opcode byte
      8'd0:   uop_o = mk_uop(FL_INC_EOF,    ACT_NOP,     ARG_NONE);
      // LD SP,nn
      8'd1:   uop_o = mk_uop(FL_INC,        ACT_FETCH,   ARG_NONE);
      8'd2:   uop_o = mk_uop(FL_INC,        ACT_LD_LO,   ARG_NONE);
      8'd3:   uop_o = mk_uop(FL_OP,         ACT_LD_HI,   ARG_NONE);
      8'd4:   uop_o = mk_uop(FL_INC_EOF,    ACT_WR_RR,   ARG_SP);
      // LD HL,nn
      8'd5:   uop_o = mk_uop(FL_INC,        ACT_FETCH,   ARG_NONE);
      8'd6:   uop_o = mk_uop(FL_INC,        ACT_LD_LO,   ARG_NONE);
      8'd7:   uop_o = mk_uop(FL_OP,         ACT_LD_HI,   ARG_NONE);
      8'd8:   uop_o = mk_uop(FL_INC_EOF,    ACT_WR_RR,   ARG_HL);
      // LD (HL-),A
      8'd9:   uop_o = mk_uop(FL_OP,         ACT_ADDR_HL, ARG_HL);
      8'd10:  uop_o = mk_uop(FL_OP,         ACT_MEM_WR,  ARG_A);
      8'd11:  uop_o = mk_uop(FL_OP,         ACT_DEC_HL,  ARG_HL);
      8'd12:  uop_o = mk_uop(FL_INC_EOF,    ACT_NOP,     ARG_NONE);
      // CB prefix: consume the second byte and branch into the CB table
      8'd13:  uop_o = mk_uop(FL_JCB,        ACT_FETCH,   ARG_NONE);
      // CB 7C: BIT 7,H
      8'd14:  uop_o = mk_uop(FL_OP,         ACT_BIT,     4'd7);
      8'd15:  uop_o = mk_uop(FL_OP,         ACT_SET_Z,   ARG_NONE);
      8'd16:  uop_o = mk_uop(FL_INC_EOF,    ACT_NOP,     ARG_NONE);
      // JR NZ,n: ends early when Z is set (branch not taken)
      8'd17:  uop_o = mk_uop(FL_INC,        ACT_FETCH,   ARG_NONE);
      8'd18:  uop_o = mk_uop(FL_OP,         ACT_LD_LO,   ARG_NONE);
      8'd19:  uop_o = mk_uop(FL_INC_EOF_Z,  ACT_NOP,     ARG_NONE);
      8'd20:  uop_o = mk_uop(FL_OP,         ACT_ADD_PC,  ARG_NONE);
      8'd21:  uop_o = mk_uop(FL_OP,         ACT_NOP,     ARG_NONE);
      8'd22:  uop_o = mk_uop(FL_EOF,        ACT_NOP,     ARG_NONE);
      // interrupt entry
      8'd32:  uop_o = mk_uop(FL_OP,         ACT_PUSH_PC, 4'd0);
      8'd33:  uop_o = mk_uop(FL_OP,         ACT_PUSH_PC, 4'd1);
      8'd34:  uop_o = mk_uop(FL_EOF,        ACT_JP_VEC,  ARG_NONE);
      // JR n: in-flow jump over the slot at 42 (base 40 + 3)
      8'd40:  uop_o = mk_uop(FL_INC,        ACT_FETCH,   ARG_NONE);
      8'd41:  uop_o = mk_uop(FL_JMP,        ACT_LD_LO,   4'd3);
      8'd42:  uop_o = mk_uop(FL_OP,         ACT_NOP,     ARG_NONE);
      8'd43:  uop_o = mk_uop(FL_INC_EOF,    ACT_ADD_PC,  ARG_NONE);
      default: uop_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dzcpu_useq.sv
`default_nettype none
// ============================================================================
// Module      : dzcpu_useq
// Description : dzcpu microcode sequencer. Dispatches macro-ops through the
//               opcode LUTs, steps the uop ROM, resolves flow control and
//               handles stall, interrupt entry and runaway-flow detection.
// Revision    : 1.0 - initial release
// ============================================================================
module dzcpu_useq
  import dzcpu_useq_pkg::*;
#(
  parameter int              UPC_W   = 8,
  parameter int              FLOW_W  = 3,
  parameter int              ACT_W   = 5,
  parameter int              ARG_W   = 4,
  parameter logic [UPC_W-1:0] IRQ_UPC = 8'd32
) (
  input  logic                          iClock,
  input  logic                          iReset,
  input  logic [7:0]                    iMop,
  input  logic                          iMopValid,
  input  logic                          iFlagZ,
  input  logic                          iStall,
  input  logic                          iIrqPending,
  output logic [FLOW_W+ACT_W+ARG_W-1:0] oUop,
  output logic                          oUopValid,
  output logic [UPC_W-1:0]              oUpc,
  output logic                          oIncPc,
  output logic                          oEof,
  output logic                          oIrqAck,
  output logic                          oUerr,
  output logic                          oBusy
);

  localparam int               UOP_W    = FLOW_W + ACT_W + ARG_W;
  localparam logic [UPC_W-1:0] UPC_ONE  = 1;
  localparam logic [UPC_W-1:0] UPC_LAST = '1;

  state_e           state_q, state_d;
  logic [UPC_W-1:0] upc_q,   upc_d;
  logic [UPC_W-1:0] base_q,  base_d;   // entry uPC of the running flow
  logic             uerr_q,  uerr_d;

  logic [UOP_W-1:0] w_rom_uop;
  logic [UPC_W-1:0] w_lut_upc;
  logic [UPC_W-1:0] w_cblut_upc;
  logic [UPC_W-1:0] w_jmp_upc;
  flow_e            w_flow;
  logic             w_inc, w_adv, w_jcb, w_jmp;
  logic             w_start;
  logic [UOP_W-1:0] w_uop;
  logic             w_uop_valid, w_inc_pc, w_eof, w_irq_ack;

  dzcpu_useq_rom u_rom (
    .upc_i       (upc_q),
    .mop_i       (iMop),
    .uop_o       (w_rom_uop),
    .lut_upc_o   (w_lut_upc),
    .cblut_upc_o (w_cblut_upc)
  );

  assign w_flow    = uop_flow(w_rom_uop);
  assign w_jmp_upc = base_q + {{(UPC_W-ARG_W){1'b0}}, uop_arg(w_rom_uop)};

  // Decode the flow field into PC-increment and next-uPC kind (end is "none of these")
  always_comb begin
    w_inc = 1'b0;
    w_adv = 1'b0;
    w_jcb = 1'b0;
    w_jmp = 1'b0;
    case (w_flow)
      FL_OP:         w_adv = 1'b1;
      FL_INC:        begin w_inc = 1'b1; w_adv = 1'b1; end
      FL_EOF:        ;
      FL_INC_EOF:    w_inc = 1'b1;
      FL_INC_EOF_Z:  begin w_inc = 1'b1; w_adv = ~iFlagZ; end
      FL_INC_EOF_NZ: begin w_inc = 1'b1; w_adv = iFlagZ; end
      FL_JCB:        begin w_inc = 1'b1; w_jcb = 1'b1; end
      FL_JMP:        w_jmp = 1'b1;
    endcase
  end

  // Next-state, next-uPC and per-cycle outputs; a stall freezes everything
  always_comb begin
    state_d     = state_q;
    upc_d       = upc_q;
    base_d      = base_q;
    uerr_d      = uerr_q;
    w_uop       = '0;
    w_uop_valid = 1'b0;
    w_inc_pc    = 1'b0;
    w_eof       = 1'b0;
    w_irq_ack   = 1'b0;
    w_start     = 1'b0;

    if (state_q == ST_EXEC) begin
      w_uop = w_rom_uop;
    end

    if (!iStall) begin
      if (state_q == ST_EXEC) begin
        w_uop_valid = 1'b1;
        w_inc_pc    = w_inc;
        if (w_adv) begin
          // Sequential step off the top of the ROM is a broken flow, never a wrap
          if (upc_q == UPC_LAST) begin
            w_eof   = 1'b1;
            uerr_d  = 1'b1;
            state_d = ST_DISPATCH;
          end else begin
            upc_d = upc_q + UPC_ONE;
          end
        end else if (w_jcb) begin
          upc_d  = w_cblut_upc;
          base_d = w_cblut_upc;
        end else if (w_jmp) begin
          upc_d = w_jmp_upc;
        end else begin
          w_eof   = 1'b1;
          w_start = 1'b1;
        end
      end else begin
        w_start = 1'b1;
      end

      // Flow boundary: interrupt wins, then a waiting macro-op, else idle
      if (w_start) begin
        if (iIrqPending) begin
          upc_d     = IRQ_UPC;
          base_d    = IRQ_UPC;
          state_d   = ST_EXEC;
          w_irq_ack = 1'b1;
        end else if (iMopValid) begin
          upc_d   = w_lut_upc;
          base_d  = w_lut_upc;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_DISPATCH;
        end
      end
    end
  end

  // Sequencer state registers
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= ST_DISPATCH;
      upc_q   <= '0;
      base_q  <= '0;
      uerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      base_q  <= base_d;
      uerr_q  <= uerr_d;
    end
  end

  assign oUop      = w_uop;
  assign oUopValid = w_uop_valid;
  assign oUpc      = upc_q;
  assign oIncPc    = w_inc_pc;
  assign oEof      = w_eof;
  assign oIrqAck   = w_irq_ack;
  assign oUerr     = uerr_q;
  assign oBusy     = (state_q == ST_EXEC);

endmodule
`default_nettype wire

// File: tb/tb_dzcpu_useq.sv
`default_nettype none
// ============================================================================
// Module      : tb_dzcpu_useq
// Description : Directed self-checking bench for the dzcpu microcode sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dzcpu_useq;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [7:0]  iMop;
  logic        iMopValid;
  logic        iFlagZ;
  logic        iStall;
  logic        iIrqPending;
  logic [11:0] oUop;
  logic        oUopValid;
  logic [7:0]  oUpc;
  logic        oIncPc;
  logic        oEof;
  logic        oIrqAck;
  logic        oUerr;
  logic        oBusy;

  int checks   = 0;
  int failures = 0;

  dzcpu_useq dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iMop        (iMop),
    .iMopValid   (iMopValid),
    .iFlagZ      (iFlagZ),
    .iStall      (iStall),
    .iIrqPending (iIrqPending),
    .oUop        (oUop),
    .oUopValid   (oUopValid),
    .oUpc        (oUpc),
    .oIncPc      (oIncPc),
    .oEof        (oEof),
    .oIrqAck     (oIrqAck),
    .oUerr       (oUerr),
    .oBusy       (oBusy)
  );

  always #5 iClock = ~iClock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  // Check one executing cycle, then advance past the next rising edge
  task automatic cyc(input string tag, input int upc, input bit inc, input bit eof, input bit vld);
    #1;
    check({tag, ".upc"},  oUpc,      upc);
    check({tag, ".inc"},  oIncPc,    inc);
    check({tag, ".eof"},  oEof,      eof);
    check({tag, ".vld"},  oUopValid, vld);
    check({tag, ".busy"}, oBusy,     1);
    tick();
  endtask

  // Present a macro-op in DISPATCH and consume it on the next edge
  task automatic start(input string tag, input logic [7:0] mop);
    iMop      = mop;
    iMopValid = 1'b1;
    #1;
    check({tag, ".idle"}, oBusy, 0);
    tick();
    iMopValid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iReset = 1'b1; iMop = 8'h00; iMopValid = 1'b0; iFlagZ = 1'b0;
    iStall = 1'b0; iIrqPending = 1'b0;
    tick(); tick();
    check("rst.uop",  oUop,      0);
    check("rst.vld",  oUopValid, 0);
    check("rst.upc",  oUpc,      0);
    check("rst.inc",  oIncPc,    0);
    check("rst.eof",  oEof,      0);
    check("rst.ack",  oIrqAck,   0);
    check("rst.uerr", oUerr,     0);
    check("rst.busy", oBusy,     0);
    iReset = 1'b0;

    // LD SP,nn
    start("ldsp", 8'h31);
    cyc("ldsp1", 1, 1, 0, 1);
    cyc("ldsp2", 2, 1, 0, 1);
    cyc("ldsp3", 3, 0, 0, 1);
    cyc("ldsp4", 4, 1, 1, 1);
    check("ldsp.done", oBusy, 0);
    check("ldsp.duop", oUop, 0);

    // CB prefix, second byte presented on the JCB cycle
    start("cb", 8'hCB);
    iMop = 8'h7C;
    cyc("cb1", 13, 1, 0, 1);
    iMop = 8'h00;
    cyc("cb2", 14, 0, 0, 1);
    cyc("cb3", 15, 0, 0, 1);
    cyc("cb4", 16, 1, 1, 1);

    // JR NZ with Z set: ends at 19
    iFlagZ = 1'b1;
    start("jrz", 8'h20);
    cyc("jrz1", 17, 1, 0, 1);
    cyc("jrz2", 18, 0, 0, 1);
    cyc("jrz3", 19, 1, 1, 1);
    // JR NZ with Z clear: runs 17..22
    iFlagZ = 1'b0;
    start("jrnz", 8'h20);
    cyc("jrnz1", 17, 1, 0, 1);
    cyc("jrnz2", 18, 0, 0, 1);
    cyc("jrnz3", 19, 1, 0, 1);
    cyc("jrnz4", 20, 0, 0, 1);
    cyc("jrnz5", 21, 0, 0, 1);
    cyc("jrnz6", 22, 0, 1, 1);

    // Back-to-back 0x00 then 0x21, with a two-cycle stall at uPC 6
    iMop = 8'h00; iMopValid = 1'b1;
    tick();
    iMop = 8'h21;
    cyc("b2b0", 0, 1, 1, 1);
    iMopValid = 1'b0;
    cyc("b2b5", 5, 1, 0, 1);
    iStall = 1'b1;
    #1;
    check("stall.uop", oUop, {3'd1, 5'd2, 4'd0});
    cyc("stall1", 6, 0, 0, 0);
    cyc("stall2", 6, 0, 0, 0);
    iStall = 1'b0;
    cyc("b2b6", 6, 1, 0, 1);
    cyc("b2b7", 7, 0, 0, 1);
    cyc("b2b8", 8, 1, 1, 1);

    // IRQ at the end of LD (HL-),A with a macro-op waiting
    start("ldd", 8'h32);
    cyc("ldd9",  9,  0, 0, 1);
    cyc("ldd10", 10, 0, 0, 1);
    cyc("ldd11", 11, 0, 0, 1);
    iIrqPending = 1'b1; iMop = 8'h31; iMopValid = 1'b1;
    #1;
    check("irq.ack", oIrqAck, 1);
    cyc("ldd12", 12, 1, 1, 1);
    iIrqPending = 1'b0;
    #1;
    check("irq.ack_once", oIrqAck, 0);
    cyc("irq32", 32, 0, 0, 1);
    cyc("irq33", 33, 0, 0, 1);
    cyc("irq34", 34, 0, 1, 1);
    iMopValid = 1'b0;
    cyc("wait1", 1, 1, 0, 1);
    cyc("wait2", 2, 1, 0, 1);
    cyc("wait3", 3, 0, 0, 1);
    cyc("wait4", 4, 1, 1, 1);

    // Stall blocks IRQ entry from DISPATCH; release enters it
    iStall = 1'b1; iIrqPending = 1'b1;
    #1;
    check("dirq.stall_ack", oIrqAck, 0);
    tick();
    check("dirq.stall_busy", oBusy, 0);
    iStall = 1'b0;
    #1;
    check("dirq.ack", oIrqAck, 1);
    tick();
    iIrqPending = 1'b0;
    cyc("dirq32", 32, 0, 0, 1);
    cyc("dirq33", 33, 0, 0, 1);
    cyc("dirq34", 34, 0, 1, 1);

    // In-flow jump skips uPC 42
    start("jr", 8'h18);
    cyc("jr40", 40, 1, 0, 1);
    cyc("jr41", 41, 0, 0, 1);
    cyc("jr43", 43, 1, 1, 1);

    // Runaway flow from 250
    start("run", 8'hD3);
    for (int u = 250; u < 255; u++) cyc("run", u, 0, 0, 1);
    #1;
    check("run.uerr_pre", oUerr, 0);
    cyc("run255", 255, 0, 1, 1);
    check("run.idle", oBusy, 0);
    check("run.uerr", oUerr, 1);
    start("post", 8'h00);
    cyc("post0", 0, 1, 1, 1);
    check("post.uerr", oUerr, 1);

    // Reset mid-flow aborts without an eof
    start("abort", 8'h31);
    cyc("abort1", 1, 1, 0, 1);
    iReset = 1'b1;
    #1;
    check("abort.eof", oEof, 0);
    tick();
    iReset = 1'b0;
    check("abort.busy", oBusy, 0);
    check("abort.upc",  oUpc,  0);
    check("abort.uerr", oUerr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dzcpu_useq.md
# dzcpu_useq

Microcode sequencer for the dzcpu core. It owns the micro-PC (uPC) and dispatches each fetched macro-op through a primary opcode LUT or a 0xCB-prefix LUT. It steps the micro-op ROM, decodes each micro-op's flow-control field (advance, end-of-flow, conditional end on Z, CB jump, in-flow jump), and adds stall, interrupt-entry and runaway-flow detection. It sits between the fetch path (which supplies opcode bytes) and the datapath (which executes the emitted micro-ops).

## Interface
- UPC_W, 8: uPC width; ROM depth is 2**UPC_W.
- FLOW_W, 3: flow-control field width (uop MSBs).
- ACT_W, 5: action field width.
- ARG_W, 4: operand field width; UOP_W = FLOW_W+ACT_W+ARG_W.
- IRQ_UPC, 8'd32: uPC of the interrupt-entry flow.
- iClock  in  1  clock; all state on rising edge.
- iReset  in  1  synchronous, active-high reset.
- iMop  in  8  current opcode byte from fetch; also the CB second byte on a JCB cycle.
- iMopValid  in  1  iMop holds a new macro-op ready for dispatch.
- iFlagZ  in  1  Z flag from the datapath.
- iStall  in  1  memory/datapath not ready; freezes the sequencer.
- iIrqPending  in  1  interrupt request, sampled only at end-of-flow.
- oUop  out  UOP_W  current micro-op; 0 when not executing.
- oUopValid  out  1  oUop is to be executed this cycle.
- oUpc  out  UPC_W  current uPC (debug).
- oIncPc  out  1  datapath increments PC this cycle.
- oEof  out  1  final micro-op of the flow.
- oIrqAck  out  1  one-cycle pulse when the IRQ flow is entered.
- oUerr  out  1  sticky runaway-flow error.
- oBusy  out  1  a flow is in progress (state EXEC).

## Operation
- States: DISPATCH and EXEC.
- DISPATCH, iMopValid=1, iStall=0, iIrqPending=0: uPC <= lut[iMop]; go to EXEC.
- Unmapped opcodes: lut returns 0, the one-cycle generic flow at uPC 0.
- CB prefix: main lut maps 0xCB to the CB fetch flow.
- EXEC: oUop = rom[uPC]; oUopValid=1 unless iStall.
- Flow codes (values 0..7 in order):
  - FL_OP: uPC+1.
  - FL_INC: uPC+1; oIncPc=1.
  - FL_EOF: end.
  - FL_INC_EOF: end; oIncPc=1.
  - FL_INC_EOF_Z: oIncPc=1; end if iFlagZ=1, else uPC+1.
  - FL_INC_EOF_NZ: oIncPc=1; end if iFlagZ=0, else uPC+1.
  - FL_JCB: oIncPc=1; uPC <= cblut[iMop]; cblut miss goes to uPC 0.
  - FL_JMP: uPC <= {arg, uPC[UPC_W-1:ARG_W]...} ⇒ uPC <= zero-extended arg + uPC base of flow; in-flow backward/forward jump.
- End (oEof=1) resolves in priority order:
  - iIrqPending=1: uPC <= IRQ_UPC, stay EXEC, oIrqAck=1; any iMopValid is left unconsumed.
  - else iMopValid=1: uPC <= lut[iMop], stay EXEC (zero-bubble back-to-back).
  - else go to DISPATCH.
- iIrqPending in DISPATCH: enter the IRQ flow as at end.
- Runaway: a non-ending uop at uPC = 2**UPC_W-1 forces oEof=1, sets oUerr, and returns to DISPATCH. uPC never wraps to 0 silently.
- oUerr clears only on reset.
- iStall=1: uPC, state and oUerr hold; oUopValid, oIncPc, oEof, oIrqAck forced 0; dispatch blocked. oUop still shows rom[uPC].

## Timing
- Reset values:
  - state DISPATCH; uPC 0.
  - oUop 0, oUopValid 0, oUpc 0, oIncPc 0, oEof 0, oIrqAck 0, oUerr 0, oBusy 0.
- iReset mid-flow aborts the flow next edge; no eof is emitted.
- Dispatch latency: iMopValid sampled at edge N; first uop valid in cycle N+1.
- ROM and LUTs are combinational from the registered uPC / iMop.
- oUop, oIncPc and oEof are combinational from registered uPC, iFlagZ and iStall.
- oIrqAck is asserted in the end cycle, and the IRQ flow's first uop follows next cycle.
- A flow of k uops with no stalls occupies exactly k cycles; each stall cycle adds one.

## Structure
- Package dzcpu_useq_pkg holds:
  - FL_* flow codes;
  - field-slice helpers for flow/action/arg;
  - opcode constants: LDSPnn 0x31, LDHLnn 0x21, LDHLDA 0x32, MAPcb 0xCB, JRNZn 0x20.
- One sub-module, dzcpu_useq_rom: the combinational lut, cblut and uop ROM, kept separate so microcode edits never touch sequencing logic.

## Test plan
- Reset, then 0x31 with stalls low:
  - uPC 1,2,3,4 in four consecutive cycles;
  - oIncPc 1,1,0,1; oEof only at uPC 4;
  - back in DISPATCH after.
- 0xCB, then 0x7C presented on the JCB cycle:
  - uPC 13,14,15,16; oEof at 16; oUpc=16 in the 4th cycle.
- 0x20 with iFlagZ=1: eof at uPC 19, 3 uops. With iFlagZ=0: uPC 17..22, 6 uops, oEof at 22.
- Back-to-back:
  - 0x00 then 0x21 with iMopValid held: uPC 0 then 5 with no DISPATCH cycle.
  - Stall 2 cycles at uPC 6: uPC holds, oUopValid=0, total 6 cycles.
- iIrqPending=1 during the eof of 0x32 (uPC 12):
  - oIrqAck pulses once; next uPC=32; pending iMopValid waits.
- Microcode with no eof from uPC 250: oEof and oUerr at uPC 255; oUerr stays 1 until iReset.
